ff_layer_engine: RTL and testbench

Parametrised single-layer feed-forward evaluator: stores one weight word per neuron in an internal synchronous RAM, and on `start` evaluates all `N_OUT` neurons sequentially against a latched binary input vector. Each neuron's output is a step activation of its bias plus selected weights. It is the next generation of the team's fixed 4-in/2-out NN block: widths, depth and neuron count are generic, with a runtime weight-load port and a start/busy/done handshake. Sits between input sampling logic and downstream decision logic.

---
 rtl/ff_nn_pkg.sv | 27 ++
 rtl/ff_weight_ram.sv | 27 ++
 rtl/ff_layer_engine.sv | 146 ++++++++++++++
 tb/tb_ff_layer_engine.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ff_nn_pkg.sv
// Shared types and sizing helpers for the feed-forward layer engine.
package ff_nn_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ACCUM,
    S_STORE,
    S_DONE
  } state_t;

  // Wide enough for a bias plus N_IN weights, all at the most negative value.
  function automatic int acc_width(input int w_bits, input int n_in);
    return w_bits + $clog2(n_in + 1);
  endfunction

  // Field 0 is the bias, field k+1 is the weight of input k.
  function automatic int field_lo(input int field, input int w_bits);
    return field * w_bits;
  endfunction

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ff_weight_ram.sv
// Single-port-write weight store with a registered read address (1-cycle read latency).
module ff_weight_ram
  import ff_nn_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int AW = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    raddr_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    raddr_q <= raddr;
  end

  assign rdata = mem[raddr_q];

endmodule

// File: rtl/ff_layer_engine.sv
// Sequential single-layer evaluator: one neuron at a time, one input per cycle,
// step activation on bias plus the weights of the active inputs.
module ff_layer_engine
  import ff_nn_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 2,
  parameter int W_BITS = 8,
  localparam int AW     = addr_width(N_OUT),
  localparam int WORD_W = (N_IN + 1) * W_BITS
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_IN-1:0]   x,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [N_OUT-1:0]  y,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  output logic              wr_err
);

  localparam int ACC_W = acc_width(W_BITS, N_IN);
  localparam int IW    = addr_width(N_IN);
  localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
  localparam logic [AW-1:0] J_LAST = AW'(N_OUT - 1);

  state_t state, next_state;

  logic [N_IN-1:0]   x_lat;
  logic [AW-1:0]     j;
  logic [IW-1:0]     i;
  logic [ACC_W-1:0]  acc;
  logic [WORD_W-1:0] word_q;
  logic [WORD_W-1:0] rdata;
  logic [N_OUT-1:0]  y_work;
  logic [N_OUT-1:0]  y_work_next;
  logic [W_BITS-1:0] sel_w;
  logic              sel_x;
  logic [ACC_W-1:0]  bias_ext;
  logic [ACC_W-1:0]  w_ext;
  logic              accept;
  logic              ram_we;

  // A start held through DONE is taken directly, so back-to-back runs need no idle cycle.
  assign accept = start && ((state == S_IDLE) || (state == S_DONE));
  assign ram_we = we && !busy && ({1'b0, waddr} < (AW + 1)'(N_OUT));

  ff_weight_ram #(
    .WIDTH (WORD_W),
    .DEPTH (N_OUT)
  ) u_ram (
    .clk   (CLK),
    .we    (ram_we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (j),
    .rdata (rdata)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_FETCH;
      S_FETCH: next_state = S_LOAD;
      S_LOAD:  next_state = S_ACCUM;
      S_ACCUM: if (i == I_LAST) next_state = S_STORE;
      S_STORE: next_state = (j == J_LAST) ? S_DONE : S_FETCH;
      S_DONE:  next_state = start ? S_FETCH : S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  always_comb begin
    sel_w = '0;
    sel_x = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      if (i == IW'(k)) begin
        sel_w = word_q[field_lo(k + 1, W_BITS) +: W_BITS];
        sel_x = x_lat[k];
      end
    end
  end

  assign bias_ext = {{(ACC_W - W_BITS){rdata[W_BITS-1]}}, rdata[W_BITS-1:0]};
  assign w_ext    = {{(ACC_W - W_BITS){sel_w[W_BITS-1]}}, sel_w};

  always_comb begin
    y_work_next = y_work;
    for (int k = 0; k < N_OUT; k++) begin
      if (j == AW'(k)) y_work_next[k] = ~acc[ACC_W-1];
    end
  end

  // The word register holds no control state, so it is left out of reset.
  always_ff @(posedge CLK) begin
    if (state == S_LOAD) word_q <= rdata;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      x_lat  <= '0;
      j      <= '0;
      i      <= '0;
      acc    <= '0;
      y_work <= '0;
      y      <= '0;
      wr_err <= 1'b0;
    end else begin
      wr_err <= we && busy;
      if (accept) begin
        x_lat <= x;
        j     <= '0;
      end
      case (state)
        S_LOAD: begin
          acc <= bias_ext;
          i   <= '0;
        end
        S_ACCUM: begin
          if (sel_x) acc <= acc + w_ext;
          i <= i + 1'b1;
        end
        S_STORE: begin
          y_work <= y_work_next;
          if (j == J_LAST) y <= y_work_next;
          else             j <= j + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ff_layer_engine.sv
// Self-checking bench for ff_layer_engine: directed cases plus randomized runs
// against an integer reference model, on three parameter sets.
module tb_ff_layer_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [3:0]  x_a;
  logic        start_a, busy_a, done_a, we_a, wr_err_a;
  logic [1:0]  y_a;
  logic [0:0]  waddr_a;
  logic [39:0] wdata_a;

  logic [0:0]  x_b;
  logic        start_b, busy_b, done_b, we_b, wr_err_b;
  logic [0:0]  y_b;
  logic [0:0]  waddr_b;
  logic [15:0] wdata_b;

  logic [6:0]  x_c;
  logic        start_c, busy_c, done_c, we_c, wr_err_c;
  logic [4:0]  y_c;
  logic [2:0]  waddr_c;
  logic [63:0] wdata_c;

  int checks = 0;
  int errors = 0;

  // Reference weights: mw[neuron][0] = bias, mw[neuron][k+1] = weight of input k.
  int mw [8][8];

  ff_layer_engine #(.N_IN(4), .N_OUT(2), .W_BITS(8)) dut_a (
    .CLK(clk), .RST(rst), .x(x_a), .start(start_a), .busy(busy_a), .done(done_a),
    .y(y_a), .we(we_a), .waddr(waddr_a), .wdata(wdata_a), .wr_err(wr_err_a)
  );

  ff_layer_engine #(.N_IN(1), .N_OUT(1), .W_BITS(8)) dut_b (
    .CLK(clk), .RST(rst), .x(x_b), .start(start_b), .busy(busy_b), .done(done_b),
    .y(y_b), .we(we_b), .waddr(waddr_b), .wdata(wdata_b), .wr_err(wr_err_b)
  );

  ff_layer_engine #(.N_IN(7), .N_OUT(5), .W_BITS(8)) dut_c (
    .CLK(clk), .RST(rst), .x(x_c), .start(start_c), .busy(busy_c), .done(done_c),
    .y(y_c), .we(we_c), .waddr(waddr_c), .wdata(wdata_c), .wr_err(wr_err_c)
  );

  function automatic logic [7:0] ref_y(input int n_in, input int n_out, input logic [7:0] xv);
    logic [7:0] r;
    int acc;
    r = '0;
    for (int jj = 0; jj < n_out; jj++) begin
      acc = mw[jj][0];
      for (int ii = 0; ii < n_in; ii++) if (xv[ii]) acc += mw[jj][ii + 1];
      r[jj] = (acc >= 0);
    end
    return r;
  endfunction

  function automatic int rand_w();
    return int'($urandom_range(255)) - 128;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_row4(input int n, input int b, input int w0, input int w1,
                          input int w2, input int w3);
    mw[n][0] = b;  mw[n][1] = w0; mw[n][2] = w1; mw[n][3] = w2; mw[n][4] = w3;
  endtask

  task automatic write_a(input int n);
    we_a = 1'b1;
    waddr_a = 1'(n);
    for (int k = 0; k < 5; k++) wdata_a[k*8 +: 8] = 8'(mw[n][k]);
    tick();
    we_a = 1'b0;
  endtask

  task automatic write_b(input int n);
    we_b = 1'b1;
    waddr_b = 1'(n);
    for (int k = 0; k < 2; k++) wdata_b[k*8 +: 8] = 8'(mw[n][k]);
    tick();
    we_b = 1'b0;
  endtask

  task automatic write_c(input int n);
    we_c = 1'b1;
    waddr_c = 3'(n);
    for (int k = 0; k < 8; k++) wdata_c[k*8 +: 8] = 8'(mw[n][k]);
    tick();
    we_c = 1'b0;
  endtask

  // Each run task returns the edge count from start acceptance to done (-1 on timeout).
  task automatic run_a(input logic [3:0] xv, output int lat, output logic [1:0] yv);
    x_a = xv;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (done_a) begin lat = c; break; end
    end
    yv = y_a;
    tick();
  endtask

  task automatic run_b(input logic [0:0] xv, output int lat, output logic [0:0] yv);
    x_b = xv;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (done_b) begin lat = c; break; end
    end
    yv = y_b;
    tick();
  endtask

  task automatic run_c(input logic [6:0] xv, output int lat, output logic [4:0] yv);
    x_c = xv;
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (done_c) begin lat = c; break; end
    end
    yv = y_c;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", done_a); end
    checks++; if (y_a !== 2'b00) begin errors++; $display("[TB] FAIL reset_y: got %b want 00", y_a); end
    checks++; if (wr_err_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_err: got %b want 0", wr_err_a); end
    checks++; if (busy_c !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy_c: got %b want 0", busy_c); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    logic [1:0] yv;
    set_row4(0, -3, 1, 1, 1, 1);
    set_row4(1, 0, -1, -1, -1, -1);
    write_a(0);
    write_a(1);
    run_a(4'b0111, lat, yv);
    checks++; if (lat !== 14) begin errors++; $display("[TB] FAIL basic_latency: got %0d want 14", lat); end
    checks++; if (yv !== 2'b01) begin errors++; $display("[TB] FAIL basic_y_0111: got %b want 01", yv); end
    run_a(4'b0000, lat, yv);
    checks++; if (yv !== 2'b10) begin errors++; $display("[TB] FAIL basic_y_0000: got %b want 10", yv); end
    repeat (3) tick();
    checks++; if (y_a !== 2'b10) begin errors++; $display("[TB] FAIL basic_y_held: got %b want 10", y_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_pulse: got %b want 0", done_a); end
  endtask

  task automatic test_boundary();
    int lat;
    logic [1:0] yv;
    set_row4(0, -4, 1, 1, 1, 1);
    write_a(0);
    run_a(4'b1111, lat, yv);
    checks++; if (yv[0] !== 1'b1) begin errors++; $display("[TB] FAIL boundary_acc_zero: got %b want 1", yv[0]); end
    run_a(4'b0111, lat, yv);
    checks++; if (yv[0] !== 1'b0) begin errors++; $display("[TB] FAIL boundary_acc_m1: got %b want 0", yv[0]); end
  endtask

  task automatic test_extremes();
    int lat;
    logic [1:0] yv;
    set_row4(0, -128, -128, -128, -128, -128);
    set_row4(1, -128, -128, -128, -128, -128);
    write_a(0);
    write_a(1);
    run_a(4'b1111, lat, yv);
    checks++; if (yv !== 2'b00) begin errors++; $display("[TB] FAIL extreme_neg: got %b want 00", yv); end
    set_row4(0, 127, 127, 127, 127, 127);
    set_row4(1, 127, 127, 127, 127, 127);
    write_a(0);
    write_a(1);
    run_a(4'b1111, lat, yv);
    checks++; if (yv !== 2'b11) begin errors++; $display("[TB] FAIL extreme_pos: got %b want 11", yv); end
  endtask

  task automatic test_write_with_start();
    int lat;
    set_row4(0, -3, 1, 1, 1, 1);
    write_a(0);
    set_row4(1, 5, -1, -1, -1, -1);
    x_a = 4'b1111;
    start_a = 1'b1;
    we_a = 1'b1;
    waddr_a = 1'b1;
    for (int k = 0; k < 5; k++) wdata_a[k*8 +: 8] = 8'(mw[1][k]);
    tick();
    start_a = 1'b0;
    we_a = 1'b0;
    checks++; if (wr_err_a !== 1'b0) begin errors++; $display("[TB] FAIL same_cycle_wr_err: got %b want 0", wr_err_a); end
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (done_a) begin lat = c; break; end
    end
    checks++; if (lat !== 14) begin errors++; $display("[TB] FAIL same_cycle_latency: got %0d want 14", lat); end
    checks++; if (y_a !== 2'b11) begin errors++; $display("[TB] FAIL same_cycle_y: got %b want 11", y_a); end
    tick();
  endtask

  task automatic test_busy_write();
    int lat, done_cnt, done_edge;
    logic [1:0] y_seen, yv;
    set_row4(0, -3, 1, 1, 1, 1);
    set_row4(1, 0, -1, -1, -1, -1);
    write_a(0);
    write_a(1);
    x_a = 4'b0111;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    checks++; if (busy_a !== 1'b1) begin errors++; $display("[TB] FAIL busy_after_start: got %b want 1", busy_a); end
    repeat (2) tick();
    we_a = 1'b1;
    waddr_a = 1'b0;
    wdata_a = {5{8'h7f}};
    tick();
    we_a = 1'b0;
    checks++; if (wr_err_a !== 1'b1) begin errors++; $display("[TB] FAIL busy_wr_err_pulse: got %b want 1", wr_err_a); end
    tick();
    checks++; if (wr_err_a !== 1'b0) begin errors++; $display("[TB] FAIL busy_wr_err_clear: got %b want 0", wr_err_a); end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    done_cnt = 0;
    done_edge = -1;
    y_seen = '0;
    for (int e = 6; e <= 40; e++) begin
      tick();
      if (done_a) begin
        done_cnt++;
        if (done_edge < 0) begin done_edge = e; y_seen = y_a; end
      end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL busy_single_done: got %0d want 1", done_cnt); end
    checks++; if (done_edge !== 14) begin errors++; $display("[TB] FAIL busy_done_edge: got %0d want 14", done_edge); end
    checks++; if (y_seen !== 2'b01) begin errors++; $display("[TB] FAIL busy_y_old_weights: got %b want 01", y_seen); end
    run_a(4'b0111, lat, yv);
    checks++; if (yv !== 2'b01) begin errors++; $display("[TB] FAIL busy_rerun_y: got %b want 01", yv); end
  endtask

  task automatic test_reset_mid();
    int lat, done_cnt;
    logic [1:0] yv;
    x_a = 4'b0000;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b want 0", busy_a); end
    checks++; if (y_a !== 2'b00) begin errors++; $display("[TB] FAIL midreset_y: got %b want 00", y_a); end
    done_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (done_a) done_cnt++;
    end
    checks++; if (done_cnt !== 0) begin errors++; $display("[TB] FAIL midreset_no_done: got %0d want 0", done_cnt); end
    run_a(4'b0000, lat, yv);
    checks++; if (lat !== 14) begin errors++; $display("[TB] FAIL midreset_latency: got %0d want 14", lat); end
    checks++; if (yv !== 2'b10) begin errors++; $display("[TB] FAIL midreset_retained_y: got %b want 10", yv); end
  endtask

  task automatic test_random_a();
    int lat;
    logic [1:0] yv;
    logic [3:0] xv;
    logic [7:0] exp;
    for (int it = 0; it < 8; it++) begin
      for (int n = 0; n < 2; n++) begin
        for (int k = 0; k < 5; k++) mw[n][k] = rand_w();
        write_a(n);
      end
      xv = 4'($urandom);
      exp = ref_y(4, 2, 8'(xv));
      run_a(xv, lat, yv);
      checks++; if (yv !== exp[1:0]) begin errors++; $display("[TB] FAIL random_a_y it=%0d x=%b: got %b want %b", it, xv, yv, exp[1:0]); end
      checks++; if (lat !== 14) begin errors++; $display("[TB] FAIL random_a_latency it=%0d: got %0d want 14", it, lat); end
    end
  endtask

  task automatic test_sweep_small();
    int lat;
    logic [0:0] yv, xv;
    logic [7:0] exp;
    for (int it = 0; it < 6; it++) begin
      mw[0][0] = rand_w();
      mw[0][1] = rand_w();
      write_b(0);
      xv = 1'($urandom);
      exp = ref_y(1, 1, 8'(xv));
      run_b(xv, lat, yv);
      checks++; if (yv !== exp[0:0]) begin errors++; $display("[TB] FAIL small_y it=%0d: got %b want %b", it, yv, exp[0]); end
      checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL small_latency it=%0d: got %0d want 4", it, lat); end
    end
  endtask

  task automatic test_sweep_big();
    int lat;
    logic [4:0] yv;
    logic [6:0] xv;
    logic [7:0] exp;
    for (int n = 0; n < 5; n++) begin
      for (int k = 0; k < 8; k++) mw[n][k] = rand_w();
      write_c(n);
    end
    for (int a = 5; a < 8; a++) begin
      we_c = 1'b1;
      waddr_c = 3'(a);
      wdata_c = {8{8'h80}};
      tick();
      we_c = 1'b0;
      checks++; if (wr_err_c !== 1'b0) begin errors++; $display("[TB] FAIL big_oob_wr_err a=%0d: got %b want 0", a, wr_err_c); end
    end
    for (int it = 0; it < 6; it++) begin
      xv = (it == 0) ? 7'h7f : 7'($urandom);
      exp = ref_y(7, 5, 8'(xv));
      run_c(xv, lat, yv);
      checks++; if (yv !== exp[4:0]) begin errors++; $display("[TB] FAIL big_y it=%0d x=%b: got %b want %b", it, xv, yv, exp[4:0]); end
      checks++; if (lat !== 50) begin errors++; $display("[TB] FAIL big_latency it=%0d: got %0d want 50", it, lat); end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    x_a = '0; start_a = 1'b0; we_a = 1'b0; waddr_a = '0; wdata_a = '0;
    x_b = '0; start_b = 1'b0; we_b = 1'b0; waddr_b = '0; wdata_b = '0;
    x_c = '0; start_c = 1'b0; we_c = 1'b0; waddr_c = '0; wdata_c = '0;
    for (int r = 0; r < 8; r++) for (int k = 0; k < 8; k++) mw[r][k] = 0;
    test_reset();
    test_basic();
    test_boundary();
    test_extremes();
    test_write_with_start();
    test_busy_write();
    test_reset_mid();
    test_random_a();
    test_sweep_small();
    test_sweep_big();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
